// File: rtl/dac_output_sequencer.sv
// Output-board sequencer between the DAC sample FIFO and the multi-DAC pin interface.
// Define DAC_SEQ_HOLD_EN to replay the last good frame (instead of zeros) during HOLD.
module dac_output_sequencer #(
    parameter int unsigned DAC_CHANNELS   = 4,
    parameter int unsigned STARTUP_CYCLES = 1024,
    parameter int unsigned MUTE_FRAMES    = 16,
    parameter int unsigned RECOVER_FRAMES = 4
) (
    input  logic                      capture_clk,
    input  logic                      capture_rst_n,
    input  logic                      dac_open,
    input  logic                      dac_underrun,
    input  logic [32*DAC_CHANNELS-1:0] src_buffer,
    output logic                      src_request,
    input  logic                      dac_request,
    output logic [32*DAC_CHANNELS-1:0] dac_buffer,
    output logic                      dac_enable,
    output logic [2:0]                seq_state,
    output logic [15:0]               underrun_count,
    output logic                      mute_active
);
    localparam int unsigned DW = 32 * DAC_CHANNELS;
    localparam int unsigned CW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int unsigned FW = $clog2(MUTE_FRAMES + 1);
    localparam int unsigned RW = $clog2(RECOVER_FRAMES + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(STARTUP_CYCLES - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(MUTE_FRAMES - 1);
    localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_MUTE    = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [FW-1:0] frm_q, frm_d;
    logic [RW-1:0] rec_q, rec_d;
    logic [15:0]   underrun_cnt_q, underrun_cnt_d;
`ifdef DAC_SEQ_HOLD_EN
    logic [DW-1:0] hold_q, hold_d;
`endif

    always_ff @(posedge capture_clk) begin
        if (!capture_rst_n) begin
            state_q        <= ST_IDLE;
            cyc_q          <= '0;
            frm_q          <= '0;
            rec_q          <= '0;
            underrun_cnt_q <= '0;
`ifdef DAC_SEQ_HOLD_EN
            hold_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cyc_q          <= cyc_d;
            frm_q          <= frm_d;
            rec_q          <= rec_d;
            underrun_cnt_q <= underrun_cnt_d;
`ifdef DAC_SEQ_HOLD_EN
            hold_q         <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        cyc_d          = cyc_q;
        frm_d          = frm_q;
        rec_d          = rec_q;
        underrun_cnt_d = underrun_cnt_q;
`ifdef DAC_SEQ_HOLD_EN
        hold_d         = hold_q;
`endif
        // Loss of dac_open outranks underrun and counter completion in every active state.
        if (!dac_open && (state_q == ST_STARTUP || state_q == ST_MUTE ||
                          state_q == ST_RUN || state_q == ST_HOLD)) begin
            state_d = ST_DRAIN;
            frm_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dac_open) begin
                        state_d = ST_STARTUP;
                        cyc_d   = '0;
                    end
                end
                ST_STARTUP: begin
                    if (cyc_q == CYC_LAST) begin
                        state_d = ST_MUTE;
                        frm_d   = '0;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
                ST_MUTE, ST_DRAIN: begin
                    if (dac_request) begin
                        if (frm_q == FRM_LAST) begin
                            state_d = (state_q == ST_MUTE) ? ST_RUN : ST_IDLE;
                        end else begin
                            frm_d = frm_q + FW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (dac_underrun) begin
                        state_d = ST_HOLD;
                        rec_d   = '0;
                        if (underrun_cnt_q != 16'hFFFF) begin
                            underrun_cnt_d = underrun_cnt_q + 16'd1;
                        end
`ifdef DAC_SEQ_HOLD_EN
                    end else if (dac_request) begin
                        hold_d = src_buffer;
`endif
                    end
                end
                ST_HOLD: begin
                    if (dac_request) begin
                        if (dac_underrun) begin
                            rec_d = '0;
                        end else if (rec_q == REC_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            rec_d = rec_q + RW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dac_buffer  = '0;
        mute_active = 1'b1;
        case (state_q)
            ST_RUN: begin
                dac_buffer  = src_buffer;
                mute_active = 1'b0;
            end
`ifdef DAC_SEQ_HOLD_EN
            ST_HOLD: begin
                dac_buffer  = hold_q;
                mute_active = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    assign src_request    = dac_request && (state_q == ST_RUN || state_q == ST_HOLD);
    assign dac_enable     = (state_q != ST_IDLE);
    assign seq_state      = state_q;
    assign underrun_count = underrun_cnt_q;

endmodule

// File: doc/dac_output_sequencer.md
Name: dac_output_sequencer

Overview:
- Sits between dac_buffer_reg (FIFO side) and multi_dac_interface (DAC pin side).
- Sequences the output board through startup, mute, run, underrun-hold and drain phases.
- Gates the DAC interface enable and forwards sample requests to the FIFO only while running.
- Substitutes zero, or last-good, frames whenever FIFO data must not reach the DACs.

Parameters:
DAC_CHANNELS, 4, number of 32-bit channel words per frame
STARTUP_CYCLES, 1024, capture_clk cycles with interface enabled before frames are counted
MUTE_FRAMES, 16, zero frames sent after startup and during drain
RECOVER_FRAMES, 4, consecutive clean requests needed to leave HOLD

Ports:
capture_clk  in  1  sole clock
capture_rst_n  in  1  synchronous active-low reset
dac_open  in  1  host FIFO open, from dac_buffer_reg
dac_underrun  in  1  FIFO underrun flag, from dac_buffer_reg
src_buffer  in  32*DAC_CHANNELS  frame from dac_buffer_reg
src_request  out  1  request to dac_buffer_reg
dac_request  in  1  one-cycle frame request, from multi_dac_interface
dac_buffer  out  32*DAC_CHANNELS  frame to multi_dac_interface
dac_enable  out  1  enable to multi_dac_interface
seq_state  out  3  current state encoding: IDLE=0, STARTUP=1, MUTE=2, RUN=3, HOLD=4, DRAIN=5
underrun_count  out  16  number of HOLD entries, saturates at 0xFFFF
mute_active  out  1  high whenever dac_buffer is forced to zero

Behaviour:
Clocking and reset
- Single clock domain. Reset is synchronous and active-low, sampled on posedge capture_clk.
- Reset values: seq_state IDLE, dac_enable 0, src_request 0, dac_buffer 0, underrun_count 0, mute_active 1, internal counters 0, hold register 0.
- Reset asserted mid-operation returns to these values on the next edge; no drain is performed.

Data path
- src_request is combinational: dac_request AND state in {RUN, HOLD}. Zero latency.
- dac_buffer is a combinational mux:
  - RUN: src_buffer.
  - HOLD: hold register.
  - All other states: 0.
- Hold register loads src_buffer on every dac_request accepted in RUN with dac_underrun=0.
- mute_active = 1 whenever dac_buffer is forced to 0.

State transitions
- IDLE: dac_enable=0. If dac_open=1, go to STARTUP and clear the cycle counter.
- STARTUP: dac_enable=1. Count capture_clk cycles. Any dac_request is answered with zeros and not forwarded. When count reaches STARTUP_CYCLES-1, go to MUTE and clear the frame counter.
- MUTE: count dac_request pulses, answering each with zeros. When the MUTE_FRAMES-th request is counted, go to RUN on the same edge.
- RUN: forward requests. If dac_underrun=1 is sampled, go to HOLD, increment underrun_count (saturating), and clear the recover counter.
- HOLD: forward requests so the FIFO keeps draining.
  - A request with dac_underrun=0 increments the recover counter.
  - A request with dac_underrun=1 clears the recover counter.
  - Re-entry increments underrun_count only on RUN->HOLD transitions.
  - When the RECOVER_FRAMES-th clean request is counted, go to RUN.
- DRAIN: dac_enable=1. Count requests, answering each with zeros. After MUTE_FRAMES requests, go to IDLE (dac_enable drops on that edge).

Priority and boundary conditions
- dac_open=0 in STARTUP, MUTE, RUN or HOLD goes to DRAIN and clears the frame counter. This has priority over underrun and over counter completion in the same cycle.
- dac_open re-asserted during DRAIN is ignored. The block completes DRAIN, passes through IDLE for one cycle, then restarts STARTUP.
- dac_request and a state change on the same edge: the request is served per the pre-edge state.
- Counters are wide enough for their parameters; the cycle counter is clog2(STARTUP_CYCLES) bits.
- underrun_count never wraps.

Optional Feature:
DAC_SEQ_HOLD_EN
- Defined: HOLD outputs the hold register (last good frame), and mute_active=0 in HOLD.
- Undefined: the hold register is not built. HOLD outputs zeros, mute_active=1 in HOLD, and all transitions are unchanged.

Test Plan:
1. Reset, then dac_open=1 with STARTUP_CYCLES=8, MUTE_FRAMES=2 -> dac_enable rises 1 cycle after open; the first 2 requests after 8 cycles return 0 with src_request=0; the 3rd request pulses src_request and dac_buffer = src_buffer (e.g. 0x0A1B0C1D...).
2. In RUN, assert dac_underrun for 1 cycle -> seq_state=4 and underrun_count=1. With HOLD_EN, dac_buffer = last good frame; without, dac_buffer=0. After 4 clean requests, seq_state=3.
3. Underrun recurs after 2 clean requests in HOLD -> the recover counter restarts, 4 further clean requests are needed, and underrun_count stays 1.
4. Drop dac_open in RUN, in the same cycle as dac_underrun=1 -> DRAIN is taken (not HOLD); the next 2 requests return 0; then IDLE with dac_enable=0.
5. Re-assert dac_open during DRAIN -> DRAIN completes, 1 cycle of IDLE, then STARTUP.
6. Assert capture_rst_n=0 during RUN, asserted low on a single clock edge -> the next edge shows all reset values; underrun_count forced to 0xFFFF saturation holds on a further underrun.
